camera_pose_ctrl: RTL and testbench

- Upstream stage feeding the mode-7 ground renderer, which needs ballx, bally and angle.
- Takes ball position from physics over a valid/ready handshake and holds the newest sample in a one-entry shadow buffer.
- Integrates left/right rotate buttons into a camera angle in the range 0..359.
- Commits position and angle once per frame at the start of vertical blank, so the renderer sees constant inputs across every active frame.

---
 rtl/camera_pose_ctrl.sv | 161 ++++++++++++++++
 tb/tb_camera_pose_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/camera_pose_ctrl.sv
// Camera pose front end for the mode-7 renderer: buffers the newest physics sample,
// integrates rotate buttons, and commits x/y/angle once per frame at vblank start.
module camera_pose_ctrl #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int ANGLE_STEP  = 1,
  parameter int FAST_STEP   = 3,
  parameter int HOLD_FRAMES = 30,
  parameter int INIT_ANGLE  = 90,
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 0
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        rotl_in,
  input  logic        rotr_in,
  input  logic        pos_valid_in,
  input  logic [15:0] ballx_in,
  input  logic [15:0] bally_in,
  output logic        pos_ready_out,
  output logic [15:0] ballx_out,
  output logic [15:0] bally_out,
  output logic [15:0] angle_out,
  output logic        frame_start_out
);

  typedef enum logic [1:0] {ROT_IDLE, ROT_SLOW, ROT_FAST} rot_state_e;

  localparam int              CNT_W     = $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]     FULL_TURN = 16'd360;
  localparam logic [15:0]     SLOW_INC  = 16'(ANGLE_STEP);
  localparam logic [15:0]     FAST_INC  = 16'(FAST_STEP);

  rot_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             dir_left_q, dir_left_d;
  logic             commit_q, commit_d;
  logic             ready_q, ready_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      ballx_q, ballx_d, bally_q, bally_d, angle_q, angle_d;
  logic [15:0]      shx_q, shx_d, shy_q, shy_d;
  logic             dir_l, dir_r, any_dir, same_dir, do_step;
  logic [15:0]      step_amt, sum, angle_l, angle_r;

  // Handshake: a sample transfers on a clock edge where pos_valid_in && pos_ready_out;
  // ready drops only during the commit cycle, so the shadow is frozen while it is copied.
  always_comb begin
    commit_d = (vcount_in == 10'(V_ACTIVE)) && (hcount_in == 11'd0) && (11'd0 < 11'(H_ACTIVE));
    ready_d  = ~commit_d;

    shx_d = shx_q;
    shy_d = shy_q;
    if (pos_valid_in && ready_q) begin
      shx_d = ballx_in;
      shy_d = bally_in;
    end

    dir_l    = rotl_in & ~rotr_in;
    dir_r    = rotr_in & ~rotl_in;
    any_dir  = dir_l | dir_r;
    same_dir = (dir_l == dir_left_q);
    cnt_inc  = (cnt_q >= HOLD_MAX) ? HOLD_MAX : cnt_q + CNT_ONE;

    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    do_step    = 1'b0;
    step_amt   = SLOW_INC;
    if (commit_q) begin
      unique case (state_q)
        ROT_IDLE: begin
          if (any_dir) begin
            state_d    = ROT_SLOW;
            cnt_d      = CNT_ONE;
            dir_left_d = dir_l;
            do_step    = 1'b1;
          end
        end
        ROT_SLOW, ROT_FAST: begin
          if (!any_dir) begin
            state_d = ROT_IDLE;
            cnt_d   = '0;
          end else if (!same_dir) begin
            state_d    = ROT_SLOW;
            cnt_d      = CNT_ONE;
            dir_left_d = dir_l;
            do_step    = 1'b1;
          end else if (state_q == ROT_FAST) begin
            do_step  = 1'b1;
            step_amt = FAST_INC;
          end else begin
            cnt_d   = cnt_inc;
            do_step = 1'b1;
            if (cnt_inc == HOLD_MAX) begin
              state_d  = ROT_FAST;
              step_amt = FAST_INC;
            end
          end
        end
        default: begin
          state_d = ROT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Both directions wrap into 0..359 without ever leaving 16 bits.
    sum     = angle_q + step_amt;
    angle_l = (sum >= FULL_TURN) ? sum - FULL_TURN : sum;
    angle_r = (angle_q < step_amt) ? angle_q + FULL_TURN - step_amt : angle_q - step_amt;

    ballx_d       = ballx_q;
    bally_d       = bally_q;
    angle_d       = angle_q;
    frame_start_d = commit_q;
    if (commit_q) begin
      ballx_d = shx_q;
      bally_d = shy_q;
      if (do_step) angle_d = dir_l ? angle_l : angle_r;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ROT_IDLE;
      cnt_q         <= '0;
      dir_left_q    <= 1'b0;
      commit_q      <= 1'b0;
      ready_q       <= 1'b0;
      frame_start_q <= 1'b0;
      ballx_q       <= 16'(INIT_X);
      bally_q       <= 16'(INIT_Y);
      angle_q       <= 16'(INIT_ANGLE);
      shx_q         <= 16'(INIT_X);
      shy_q         <= 16'(INIT_Y);
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_left_q    <= dir_left_d;
      commit_q      <= commit_d;
      ready_q       <= ready_d;
      frame_start_q <= frame_start_d;
      ballx_q       <= ballx_d;
      bally_q       <= bally_d;
      angle_q       <= angle_d;
      shx_q         <= shx_d;
      shy_q         <= shy_d;
    end
  end

  assign pos_ready_out   = ready_q;
  assign ballx_out       = ballx_q;
  assign bally_out       = bally_q;
  assign angle_out       = angle_q;
  assign frame_start_out = frame_start_q;

endmodule

// File: tb/tb_camera_pose_ctrl.sv
// Directed bench for camera_pose_ctrl using compressed 10-cycle frames around the commit point.
module tb_camera_pose_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        rotl, rotr, pos_valid;
  logic [15:0] bx_in, by_in;
  logic        pos_ready, frame_start;
  logic [15:0] ballx, bally, angle;

  camera_pose_ctrl dut (
    .pixel_clk_in    (clk),
    .rst_n_in        (rst_n),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .rotl_in         (rotl),
    .rotr_in         (rotr),
    .pos_valid_in    (pos_valid),
    .ballx_in        (bx_in),
    .bally_in        (by_in),
    .pos_ready_out   (pos_ready),
    .ballx_out       (ballx),
    .bally_out       (bally),
    .angle_out       (angle),
    .frame_start_out (frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] obs_x[10];
  logic [15:0] obs_y[10];
  logic [15:0] obs_a[10];
  logic        obs_fs[10];
  logic        obs_rdy[10];

  typedef struct {
    string       name;
    logic        rl;
    logic        rr;
    int          n;
    logic [15:0] exp_angle;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Entered just after a rising edge; samples outputs on the falling edge.
  task automatic step(input logic [10:0] h, input logic [9:0] v, input int idx);
    hcount = h;
    vcount = v;
    @(negedge clk);
    obs_x[idx]   = ballx;
    obs_y[idx]   = bally;
    obs_a[idx]   = angle;
    obs_fs[idx]  = frame_start;
    obs_rdy[idx] = pos_ready;
    @(posedge clk);
    #1;
  endtask

  // Frame: idx 0..5 active line, 6 = commit point (720,0), 7 = commit cycle, 8 = load pulse.
  task automatic run_frame(input string tag, input logic rl, input logic rr,
                           input int va, input logic [15:0] xa, input logic [15:0] ya,
                           input int vb, input logic [15:0] xb, input logic [15:0] yb);
    logic [9:0] fs_pat;
    logic [9:0] rdy_pat;
    rotl = rl;
    rotr = rr;
    for (int i = 0; i < 10; i++) begin
      if (i == va) begin
        pos_valid = 1'b1; bx_in = xa; by_in = ya;
      end else if (i == vb) begin
        pos_valid = 1'b1; bx_in = xb; by_in = yb;
      end else begin
        pos_valid = 1'b0;
      end
      if (i < 6) step(11'(i * 100), 10'd10, i);
      else       step(11'(i - 6), 10'd720, i);
    end
    pos_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      fs_pat[i]  = obs_fs[i];
      rdy_pat[i] = obs_rdy[i];
    end
    check({tag, "_fs_pulse"}, 16'(fs_pat), 16'b01_0000_0000);
    check({tag, "_ready"}, 16'(rdy_pat), 16'b11_0111_1111);
  endtask

  initial begin
    tbl[0]  = '{"idle",        1'b0, 1'b0,  2, 16'd90};
    tbl[1]  = '{"l_slow",      1'b1, 1'b0, 29, 16'd119};
    tbl[2]  = '{"l_fast",      1'b1, 1'b0,  1, 16'd122};
    tbl[3]  = '{"l_fast_run",  1'b1, 1'b0,  5, 16'd137};
    tbl[4]  = '{"both",        1'b1, 1'b1,  1, 16'd137};
    tbl[5]  = '{"l_after_both",1'b1, 1'b0,  1, 16'd138};
    tbl[6]  = '{"release1",    1'b0, 1'b0,  1, 16'd138};
    tbl[7]  = '{"r_slow",      1'b0, 1'b1, 29, 16'd109};
    tbl[8]  = '{"r_fast",      1'b0, 1'b1,  1, 16'd106};
    tbl[9]  = '{"r_fast_run",  1'b0, 1'b1, 35, 16'd1};
    tbl[10] = '{"release2",    1'b0, 1'b0,  1, 16'd1};
    tbl[11] = '{"r_to_0",      1'b0, 1'b1,  1, 16'd0};
    tbl[12] = '{"r_wrap",      1'b0, 1'b1,  1, 16'd359};
    tbl[13] = '{"r_358",       1'b0, 1'b1,  1, 16'd358};
    tbl[14] = '{"r_slow2",     1'b0, 1'b1, 26, 16'd332};
    tbl[15] = '{"r_fast2",     1'b0, 1'b1,  1, 16'd329};
    tbl[16] = '{"r_fast3",     1'b0, 1'b1,  1, 16'd326};
    tbl[17] = '{"release3",    1'b0, 1'b0,  1, 16'd326};
    tbl[18] = '{"l_slow3",     1'b1, 1'b0, 29, 16'd355};
    tbl[19] = '{"l_fast4",     1'b1, 1'b0,  1, 16'd358};
    tbl[20] = '{"l_wrap_fast", 1'b1, 1'b0,  1, 16'd1};
    tbl[21] = '{"r_opp_fast",  1'b0, 1'b1,  1, 16'd0};
    tbl[22] = '{"l_opp_slow",  1'b1, 1'b0,  1, 16'd1};
    tbl[23] = '{"release4",    1'b0, 1'b0,  1, 16'd1};

    // Clock/reset block: asynchronous assertion before any clock edge.
    rst_n = 1'b1; hcount = 11'd0; vcount = 10'd10;
    rotl = 1'b0; rotr = 1'b0; pos_valid = 1'b0; bx_in = 16'd0; by_in = 16'd0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ballx", ballx, 16'd0);
    check("rst_bally", bally, 16'd0);
    check("rst_angle", angle, 16'd90);
    check("rst_fs",    16'(frame_start), 16'd0);
    check("rst_ready", 16'(pos_ready), 16'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 16'(pos_ready), 16'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 16'(pos_ready), 16'd1);

    // Free-running with nothing pressed.
    for (int f = 0; f < 2; f++) begin
      run_frame("quiet", 1'b0, 1'b0, -1, 16'd0, 16'd0, -1, 16'd0, 16'd0);
      check("quiet_angle", obs_a[9], 16'd90);
      check("quiet_ballx", obs_x[9], 16'd0);
      check("quiet_bally", obs_y[9], 16'd0);
    end

    // Two mid-frame samples: the newer one wins, nothing moves before the commit.
    run_frame("pos", 1'b0, 1'b0, 1, 16'd100, 16'd200, 2, 16'd101, 16'd201);
    check("pos_pre_x", obs_x[7], 16'd0);
    check("pos_pre_y", obs_y[7], 16'd0);
    check("pos_x", obs_x[9], 16'd101);
    check("pos_y", obs_y[9], 16'd201);

    // Valid raised on the commit cycle is refused, then taken the next cycle.
    run_frame("late", 1'b0, 1'b0, 7, 16'd300, 16'd400, 8, 16'd300, 16'd400);
    check("late_x_this_frame", obs_x[9], 16'd101);
    check("late_y_this_frame", obs_y[9], 16'd201);
    run_frame("late2", 1'b0, 1'b0, -1, 16'd0, 16'd0, -1, 16'd0, 16'd0);
    check("late_x_next_frame", obs_x[9], 16'd300);
    check("late_y_next_frame", obs_y[9], 16'd400);

    // Rotation table.
    for (int t = 0; t < 24; t++) begin
      for (int f = 0; f < tbl[t].n; f++)
        run_frame(tbl[t].name, tbl[t].rl, tbl[t].rr, -1, 16'd0, 16'd0, -1, 16'd0, 16'd0);
      check({tbl[t].name, "_angle"}, obs_a[9], tbl[t].exp_angle);
    end
    check("table_ballx_held", obs_x[9], 16'd300);

    // Mid-frame asynchronous reset.
    rotl = 1'b0; rotr = 1'b0;
    step(11'd0, 10'd10, 0);
    step(11'd100, 10'd10, 1);
    rst_n = 1'b0;
    #2;
    check("midrst_ballx", ballx, 16'd0);
    check("midrst_bally", bally, 16'd0);
    check("midrst_angle", angle, 16'd90);
    check("midrst_ready", 16'(pos_ready), 16'd0);
    check("midrst_fs",    16'(frame_start), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("post_rst", 1'b0, 1'b0, -1, 16'd0, 16'd0, -1, 16'd0, 16'd0);
    check("post_rst_angle", obs_a[9], 16'd90);
    check("post_rst_shadow_x", obs_x[9], 16'd0);
    check("post_rst_shadow_y", obs_y[9], 16'd0);
    run_frame("post_rst_l", 1'b1, 1'b0, -1, 16'd0, 16'd0, -1, 16'd0, 16'd0);
    check("post_rst_l_angle", obs_a[9], 16'd91);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
